// File: rtl/eq2_seq_pkg.sv
// Shared definitions for the eq2 sequencing controller: FSM state encoding
// and the slice-index width helper.
package eq2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-slice operand still needs a 1-bit index port.
  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/eq2_seq_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// eq2 sequencing controller (slave).
interface eq2_seq_ctrl_if
  import eq2_seq_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int IW = idx_width(WIDTH / 2);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             aeqb;
  logic [IW-1:0]    slice_idx;

  modport master (
    output start, a, b,
    input  busy, done, aeqb, slice_idx
  );

  modport slave (
    input  start, a, b,
    output busy, done, aeqb, slice_idx
  );

endinterface

// File: rtl/eq2.sv
// Existing 2-bit equality comparator leaf, shared across all slices.
module eq2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       aeqb
);

  // Sum of the four equal-pattern products.
  assign aeqb = (~a[1] & ~a[0] & ~b[1] & ~b[0]) |
                (~a[1] &  a[0] & ~b[1] &  b[0]) |
                ( a[1] & ~a[0] &  b[1] & ~b[0]) |
                ( a[1] &  a[0] &  b[1] &  b[0]);

endmodule

// File: rtl/eq2_seq_ctrl.sv
// Time-shares one eq2 comparator over WIDTH/2 slices, LSB-first.
// Optional feature macro: EQ2_SEQ_EARLY_EXIT_EN (finish on first mismatch).
module eq2_seq_ctrl
  import eq2_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  eq2_seq_ctrl_if.slave  bus
);

  localparam int SLICES = WIDTH / 2;
  localparam int IW     = idx_width(SLICES);
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             acc;
  logic             busy_q;
  logic             done_q;
  logic             aeqb_q;
  logic [1:0]       a_slice;
  logic [1:0]       b_slice;
  logic             eq;

  always_comb begin
    a_slice = a_q[{idx, 1'b0} +: 2];
    b_slice = b_q[{idx, 1'b0} +: 2];
  end

  eq2 u_eq2 (
    .a    (a_slice),
    .b    (b_slice),
    .aeqb (eq)
  );

  // aeqb is loaded with the final accumulated value on the edge entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      acc    <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      aeqb_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            idx    <= '0;
            acc    <= 1'b1;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc & eq;
`ifdef EQ2_SEQ_EARLY_EXIT_EN
          if (!eq || idx == LAST) begin
`else
          if (idx == LAST) begin
`endif
            state  <= DONE;
            done_q <= 1'b1;
            aeqb_q <= acc & eq;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aeqb      = aeqb_q;
  assign bus.slice_idx = idx;

endmodule

// File: tb/tb_eq2_seq_ctrl.sv
// Self-checking bench for eq2_seq_ctrl (WIDTH=8), behavioural model plus
// directed scenarios; honours EQ2_SEQ_EARLY_EXIT_EN like the design.
module tb_eq2_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int SLICES = WIDTH / 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;

  eq2_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  eq2_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Operation length in RUN cycles, derived from the operands alone.
  function automatic int expLatency(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
`ifdef EQ2_SEQ_EARLY_EXIT_EN
    for (int k = 0; k < SLICES; k++)
      if (av[2*k +: 2] != bv[2*k +: 2]) return k + 1;
`endif
    return SLICES;
  endfunction

  // Model: t counts edges since the accepting edge of the current operation.
  bit m_active   = 1'b0;
  int m_t        = 0;
  int m_len      = 0;
  bit m_res      = 1'b0;
  bit exp_busy   = 1'b0;
  bit exp_done   = 1'b0;
  bit exp_aeqb   = 1'b0;
  int exp_idx    = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_aeqb = 1'b0;
      exp_idx  = 0;
    end else begin
      if (m_active) begin
        m_t++;
        if (m_t > m_len) m_active = 1'b0;
      end else if (bus.start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_len    = expLatency(bus.a, bus.b);
        m_res    = (bus.a == bus.b);
      end
      exp_done = 1'b0;
      exp_busy = m_active;
      if (m_active) begin
        exp_idx = (m_t < m_len - 1) ? m_t : m_len - 1;
        if (m_t == m_len) begin
          exp_done = 1'b1;
          exp_aeqb = m_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy", int'(bus.busy), int'(exp_busy));
    checkOutput("done", int'(bus.done), int'(exp_done));
    checkOutput("aeqb", int'(bus.aeqb), int'(exp_aeqb));
    checkOutput("slice_idx", int'(bus.slice_idx), exp_idx);
    if (bus.done) doneCount++;
  end

  // One start pulse; returns cycles to done (1 = cycle after accepting edge).
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               output int lat, output logic res, output int busyCycles);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    lat        = 1;
    busyCycles = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busyCycles++;
    end
    res = bus.aeqb;
    @(posedge clk); #1;
    if (bus.busy) busyCycles++;
  endtask

  initial begin
    int   lat;
    int   bc;
    int   d0;
    int   c1;
    int   c2;
    int   np;
    logic res;
    logic r1;
    logic r2;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_aeqb", int'(bus.aeqb), 0);
    checkOutput("rst_idx", int'(bus.slice_idx), 0);
    #1 reset_n = 1'b1;

    // 1: equal operands
    applyStimulus(8'hA5, 8'hA5, lat, res, bc);
    checkOutput("t1_latency", lat, 5);
    checkOutput("t1_aeqb", int'(res), 1);
    checkOutput("t1_busy_cycles", bc, 5);

    // 2: mismatch in slice 0
    applyStimulus(8'hA5, 8'hA4, lat, res, bc);
`ifdef EQ2_SEQ_EARLY_EXIT_EN
    checkOutput("t2_latency", lat, 2);
`else
    checkOutput("t2_latency", lat, 5);
`endif
    checkOutput("t2_aeqb", int'(res), 0);

    // 3: mismatch in top slice, slice_idx walks 0..3
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h25;
    bus.b     = 8'hA5;
    for (int k = 0; k < SLICES; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      checkOutput("t3_slice_idx", int'(bus.slice_idx), k);
    end
    @(posedge clk); #1;
    checkOutput("t3_done", int'(bus.done), 1);
    checkOutput("t3_aeqb", int'(bus.aeqb), 0);
    @(posedge clk); #1;

    // 4: operand change and start during RUN are ignored
    d0 = doneCount;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'h3C;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.a     = 8'h00;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t4_aeqb", int'(bus.aeqb), 1);
    checkOutput("t4_done_pulses", doneCount - d0, 1);

    // 5: reset mid-RUN aborts, then a fresh start works
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h5A;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t5_busy", int'(bus.busy), 0);
    checkOutput("t5_done", int'(bus.done), 0);
    checkOutput("t5_aeqb", int'(bus.aeqb), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    d0 = doneCount;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t5_no_done", doneCount - d0, 0);
    applyStimulus(8'hFF, 8'hFF, lat, res, bc);
    checkOutput("t5_latency", lat, 5);
    checkOutput("t5_aeqb_after", int'(res), 1);

    // 6: start held high, equal then unequal (top-slice mismatch)
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h11;
    np = 0;
    c1 = -1;
    c2 = -1;
    r1 = 1'b0;
    r2 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.b = 8'h51;
      if (c == 7) bus.start = 1'b0;
      if (bus.done) begin
        if (np == 0) begin c1 = c; r1 = bus.aeqb; end
        else if (np == 1) begin c2 = c; r2 = bus.aeqb; end
        np++;
      end
    end
    checkOutput("t6_pulses", np, 2);
    checkOutput("t6_first_cycle", c1, 4);
    checkOutput("t6_spacing", c2 - c1, 6);
    checkOutput("t6_aeqb_first", int'(r1), 1);
    checkOutput("t6_aeqb_second", int'(r2), 0);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eq2_seq_ctrl.md
# eq2_seq_ctrl

Sequencing controller that compares two WIDTH-bit operands for equality by time-sharing a single `eq2` 2-bit comparator across successive 2-bit slices. It latches the operands on a start request, walks the slices LSB-first one per clock, accumulates the result, and reports it with a one-cycle done pulse. It sits between a requesting datapath and the existing `eq2` leaf, trading latency for comparator area.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; must be even and ≥ 2.
- SLICES = WIDTH/2 (derived, not overridable): number of 2-bit slices.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request; sampled only in IDLE.
- a, input, WIDTH: operand A; latched on accepted start.
- b, input, WIDTH: operand B; latched on accepted start.
- busy, output, 1: high whenever state ≠ IDLE.
- done, output, 1: one-cycle pulse when the result is valid.
- aeqb, output, 1: result, 1 = operands equal; held until the next done.
- slice_idx, output, max(1,$clog2(SLICES)): slice currently presented to `eq2`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch a→a_q and b→b_q, set idx=0 and acc=1, go to RUN. Otherwise stay.
- RUN: `eq2` compares a_q[2·idx+1:2·idx] with b_q[2·idx+1:2·idx] combinationally. Update acc ← acc & eq. If idx = SLICES−1, go to DONE. Otherwise increment idx. See Configuration for early exit.
- DONE: assert done for this cycle and drive aeqb from acc. Return to IDLE unconditionally.
- start is ignored in RUN and DONE. Changes on a and b after acceptance have no effect.
- aeqb changes only on entry to DONE and otherwise keeps its last value.
- idx never exceeds SLICES−1, so there is no wrap-around. idx resets to 0 on every accepted start.
- WIDTH=2 (SLICES=1): RUN lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, aeqb=0, slice_idx=0, acc=1. The a_q and b_q registers are cleared to 0.
- Reset asserted mid-RUN or mid-DONE aborts the comparison immediately: busy=0, no done pulse, and aeqb returns to 0. The first start after reset release is accepted normally.
- Latency, with start sampled high at edge 0:
  - busy is high from edge 0 onward.
  - RUN occupies edges 1..SLICES.
  - done=1 during the cycle after edge SLICES.
  - busy falls after the DONE cycle.
- Throughput with start held high: one operation every SLICES+2 cycles (RUN cycles + DONE + IDLE).
- done and aeqb are registered outputs. There are no combinational paths from start, a or b to any output.

## Configuration
- EQ2_SEQ_EARLY_EXIT_EN defined:
  - In RUN, if eq=0 the FSM moves to DONE immediately, with acc=0.
  - A mismatch in slice k produces done k+1 cycles after the accepting edge.
  - Equal operands still take the full SLICES cycles.
- EQ2_SEQ_EARLY_EXIT_EN undefined:
  - Latency is always SLICES RUN cycles, independent of the data.
  - A mismatch only clears acc.

## Structure
- Shared package eq2_seq_pkg holds:
  - the state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the slice-index width helper function.
- One sub-module: the existing `eq2` (ports a, b, aeqb), instantiated once and fed by the idx-selected slice mux.
- The FSM, idx counter and accumulator live in the top module.

## Test plan
All scenarios use WIDTH=8 (SLICES=4).

1. a=b=8'hA5, start pulse → busy high for 5 cycles, done at cycle 5, aeqb=1.
2. a=8'hA5, b=8'hA4 (mismatch in slice 0):
   - macro off → done at cycle 5, aeqb=0;
   - macro on → done at cycle 2, aeqb=0.
3. a=8'h25, b=8'hA5 (mismatch in top slice) → done at cycle 5, aeqb=0 in both configs; slice_idx steps 0,1,2,3.
4. Start with a=b=8'h3C, then during RUN drive a=8'h00 and pulse start → result is aeqb=1 from the latched operands, and only one done pulse occurs.
5. reset_n low at cycle 2 of RUN → busy=0, done=0 and aeqb=0 at once, with no done pulse afterwards. A new start with a=b=8'hFF after release gives done with aeqb=1.
6. start held high with a=b, then a≠b → done pulses 6 cycles apart, with aeqb sequence 1, 0.
